// File: rtl/shot_pkg.sv
// shot_pkg: shared state encoding, screen defaults and coordinate helpers for the shot controller.
package shot_pkg;
  localparam int COORD_W = 12;
  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    FIRE     = 3'd2,
    FLIGHT   = 3'd3,
    COOLDOWN = 3'd4,
    RELOAD   = 3'd5
  } state_e;
  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v, input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter stepped by frame ticks; done while the count is zero.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (tick_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/shot_controller.sv
// shot_controller: frame-aligned fire sequencer with flight, cooldown, ammo, reload and score tracking.
// Define SHOT_AUTO_FIRE_EN to let a held button refire whenever the controller returns to IDLE.
module shot_controller
  import shot_pkg::*;
#(
  parameter int AMMO_MAX        = 8,
  parameter int COOLDOWN_FRAMES = 10,
  parameter int RELOAD_FRAMES   = 60,
  parameter int FLIGHT_TIMEOUT  = 120,
  parameter int SCREEN_W        = SCREEN_W_DEF,
  parameter int SCREEN_H        = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_sync_in,
  input  logic               left_click,
  input  logic               reload_req,
  input  logic [COORD_W-1:0] x_pos_in,
  input  logic [COORD_W-1:0] y_pos_in,
  input  logic               shot_done,
  input  logic               hit,
  output logic               fire,
  output logic               frame_step,
  output logic [COORD_W-1:0] target_x,
  output logic [COORD_W-1:0] target_y,
  output logic               busy,
  output logic [3:0]         ammo,
  output logic [7:0]         score
);
  localparam int FMAX = (FLIGHT_TIMEOUT > COOLDOWN_FRAMES)
                      ? ((FLIGHT_TIMEOUT > RELOAD_FRAMES) ? FLIGHT_TIMEOUT : RELOAD_FRAMES)
                      : ((COOLDOWN_FRAMES > RELOAD_FRAMES) ? COOLDOWN_FRAMES : RELOAD_FRAMES);
  localparam int CW = $clog2(FMAX) + 1;
  localparam logic [3:0] AMMO_FULL = 4'(AMMO_MAX);
  state_e state_q, state_d;
  logic click_d_q, vs_d_q, click_rise_q, tick_q;
  logic fire_q, fire_d, step_q, step_d, busy_q;
  logic [COORD_W-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [3:0] ammo_q, ammo_d;
  logic [7:0] score_q, score_d;
  logic tmr_load, tmr_done, trig;
  logic [CW-1:0] tmr_val;
`ifdef SHOT_AUTO_FIRE_EN
  assign trig = click_rise_q | click_d_q;
`else
  assign trig = click_rise_q;
`endif
  frame_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (tick_q),
    .done_o     (tmr_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      click_d_q    <= 1'b0;
      vs_d_q       <= 1'b0;
      click_rise_q <= 1'b0;
      tick_q       <= 1'b0;
      fire_q       <= 1'b0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      tx_q         <= '0;
      ty_q         <= '0;
      ammo_q       <= AMMO_FULL;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      click_d_q    <= left_click;
      vs_d_q       <= v_sync_in;
      click_rise_q <= left_click & ~click_d_q;
      tick_q       <= v_sync_in & ~vs_d_q;
      fire_q       <= fire_d;
      step_q       <= step_d;
      busy_q       <= state_d != IDLE;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      ammo_q       <= ammo_d;
      score_q      <= score_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    fire_d   = 1'b0;
    step_d   = 1'b0;
    tx_d     = tx_q;
    ty_d     = ty_q;
    ammo_d   = ammo_q;
    score_d  = score_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (ammo_q == '0 || (reload_req && ammo_q < AMMO_FULL)) begin
          state_d  = RELOAD;
          tmr_load = 1'b1;
          tmr_val  = CW'(RELOAD_FRAMES);
        end else if (trig) begin
          tx_d    = clamp(x_pos_in, COORD_W'(SCREEN_W - 1));
          ty_d    = (y_pos_in == '0) ? COORD_W'(1) : clamp(y_pos_in, COORD_W'(SCREEN_H - 1));
          ammo_d  = ammo_q - 4'd1;
          state_d = ARM;
        end
      end
      ARM: begin
        fire_d  = tick_q;
        state_d = tick_q ? FIRE : ARM;
      end
      FIRE: begin
        state_d  = FLIGHT;
        tmr_load = 1'b1;
        tmr_val  = CW'(FLIGHT_TIMEOUT);
      end
      FLIGHT: begin
        // the timer reaching zero means the last allowed step has already been issued
        step_d  = tick_q & ~tmr_done;
        score_d = (hit && score_q != 8'hff) ? score_q + 8'd1 : score_q;
        if (hit || shot_done || tmr_done) begin
          state_d  = COOLDOWN;
          tmr_load = 1'b1;
          tmr_val  = CW'(COOLDOWN_FRAMES);
        end
      end
      COOLDOWN: begin
        if (tmr_done) begin
          state_d  = (ammo_q == '0) ? RELOAD : IDLE;
          tmr_load = ammo_q == '0;
          tmr_val  = CW'(RELOAD_FRAMES);
        end
      end
      RELOAD: begin
        if (tmr_done) begin
          ammo_d  = AMMO_FULL;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign fire       = fire_q;
  assign frame_step = step_q;
  assign target_x   = tx_q;
  assign target_y   = ty_q;
  assign busy       = busy_q;
  assign ammo       = ammo_q;
  assign score      = score_q;
endmodule

// File: tb/tb_shot_controller.sv
// tb_shot_controller: scoreboard bench; expected fire targets and ammo are queued at click time and checked on each fire.
module tb_shot_controller;
  logic clk = 1'b0, rst = 1'b1, v_sync_in = 1'b0, left_click = 1'b0, reload_req = 1'b0;
  logic shot_done = 1'b0, hit = 1'b0;
  logic [11:0] x_pos_in = '0, y_pos_in = '0;
  logic fire, frame_step, busy;
  logic [11:0] target_x, target_y;
  logic [3:0] ammo;
  logic [7:0] score;
  int tests = 0, fails = 0, fire_cnt = 0, step_cnt = 0, hold_exp = 0;
  logic [27:0] exp_q[$];
  logic [27:0] exp_e;
  shot_controller dut (
    .clk        (clk),
    .rst        (rst),
    .v_sync_in  (v_sync_in),
    .left_click (left_click),
    .reload_req (reload_req),
    .x_pos_in   (x_pos_in),
    .y_pos_in   (y_pos_in),
    .shot_done  (shot_done),
    .hit        (hit),
    .fire       (fire),
    .frame_step (frame_step),
    .target_x   (target_x),
    .target_y   (target_y),
    .busy       (busy),
    .ammo       (ammo),
    .score      (score)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst && fire) begin
      fire_cnt++;
      if (exp_q.size() == 0) check("fire_unexpected", 1, 0);
      else begin
        exp_e = exp_q.pop_front();
        check("fire_tx", target_x, exp_e[27:16]);
        check("fire_ty", target_y, exp_e[15:4]);
        check("fire_ammo", ammo, exp_e[3:0]);
      end
    end
    if (!rst && frame_step) step_cnt++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic frame();
    v_sync_in = 1'b1;
    cyc(2);
    v_sync_in = 1'b0;
    cyc(2);
  endtask
  task automatic frames(input int n);
    repeat (n) frame();
  endtask
  task automatic click(input logic [11:0] x, input logic [11:0] y);
    x_pos_in = x;
    y_pos_in = y;
    left_click = 1'b1;
    cyc(2);
    left_click = 1'b0;
    cyc(1);
  endtask
  task automatic shoot(input logic [11:0] x, input logic [11:0] y, input logic [11:0] ex, input logic [11:0] ey, input logic [3:0] am);
    exp_q.push_back({ex, ey, am});
    click(x, y);
    frame();
  endtask
  task automatic pulse_done();
    shot_done = 1'b1;
    cyc(1);
    shot_done = 1'b0;
    cyc(1);
  endtask
  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_busy", busy, 0);
    check("rst_fire", fire, 0);
    check("rst_step", frame_step, 0);
    check("rst_tx", target_x, 0);
    check("rst_ty", target_y, 0);
    check("rst_ammo", ammo, 8);
    check("rst_score", score, 0);
    exp_q.push_back({12'd300, 12'd200, 4'd7});
    click(300, 200);
    check("arm_busy", busy, 1);
    check("arm_ammo", ammo, 7);
    check("arm_tx", target_x, 300);
    check("arm_ty", target_y, 200);
    check("arm_nofire", fire_cnt, 0);
    frame();
    check("basic_fire", fire_cnt, 1);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(1);
    check("basic_score", score, 1);
    frames(9);
    check("cool_busy", busy, 1);
    frames(1);
    check("basic_idle", busy, 0);
    shoot(1023, 0, 799, 1, 6);
    check("clamp_fire", fire_cnt, 2);
    repeat (3) begin click(5, 5); frame(); end
    pulse_done();
    repeat (2) begin click(6, 6); frame(); end
    frames(8);
    check("ign_idle", busy, 0);
    check("ign_fire", fire_cnt, 2);
    check("ign_ammo", ammo, 6);
    check("ign_tx", target_x, 799);
    check("done_noscore", score, 1);
    shoot(10, 20, 10, 20, 5);
    step_cnt = 0;
    frames(119);
    check("to_busy", busy, 1);
    check("to_steps119", step_cnt, 119);
    frames(1);
    check("to_steps120", step_cnt, 120);
    frames(1);
    check("to_cool_steps", step_cnt, 120);
    frames(9);
    check("to_idle", busy, 0);
    shoot(50, 60, 50, 60, 4);
    hit = 1'b1;
    shot_done = 1'b1;
    cyc(1);
    hit = 1'b0;
    shot_done = 1'b0;
    cyc(1);
    check("coinc_score", score, 2);
    frames(10);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(1);
    check("hit_idle", score, 2);
    for (int i = 0; i < 4; i++) begin
      shoot(12'(100 + i), 100, 12'(100 + i), 100, 4'(3 - i));
      pulse_done();
      frames(10);
    end
    check("ex_fires", fire_cnt, 8);
    check("ex_ammo", ammo, 0);
    check("ex_reload_busy", busy, 1);
    repeat (59) begin click(1, 1); frame(); end
    check("ex_still_busy", busy, 1);
    check("ex_no_fire", fire_cnt, 8);
    frames(1);
    check("ex_refill", ammo, 8);
    check("ex_idle", busy, 0);
    shoot(7, 7, 7, 7, 7);
    pulse_done();
    frames(10);
    reload_req = 1'b1;
    left_click = 1'b1;
    cyc(2);
    reload_req = 1'b0;
    left_click = 1'b0;
    cyc(1);
    check("rl_busy", busy, 1);
    check("rl_ammo", ammo, 7);
    frame();
    check("rl_drop", fire_cnt, 9);
    frames(59);
    check("rl_refill", ammo, 8);
    check("rl_idle", busy, 0);
    exp_q.push_back({12'd400, 12'd300, 4'd7});
    hold_exp = 10;
`ifdef SHOT_AUTO_FIRE_EN
    exp_q.push_back({12'd400, 12'd300, 4'd6});
    hold_exp = 11;
`endif
    x_pos_in = 400;
    y_pos_in = 300;
    left_click = 1'b1;
    cyc(3);
    frame();
    pulse_done();
    frames(12);
    left_click = 1'b0;
    cyc(1);
    check("hold_fires", fire_cnt, hold_exp);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    click(20, 20);
    check("rarm_busy", busy, 1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    frames(2);
    check("rarm_nofire", fire_cnt, hold_exp);
    check("rarm_ammo", ammo, 8);
    check("rarm_score", score, 0);
    check("rarm_busy0", busy, 0);
    check("rarm_tx", target_x, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Frame-synchronous sequencer for the projectile renderer in the VGA pipeline.
- Turns mouse clicks into single, frame-aligned fire commands carrying a latched, clamped target.
- Tracks flight, cooldown, ammunition, reload and hit score, and supplies a per-frame step strobe so the renderer advances the bullet once per frame.

Parameters:
- AMMO_MAX, 8: magazine size (1..15)
- COOLDOWN_FRAMES, 10: frames between end of flight and next allowed shot (>=1)
- RELOAD_FRAMES, 60: frames to refill the magazine (>=1)
- FLIGHT_TIMEOUT, 120: frames before an unfinished flight is force-terminated (>=1)
- SCREEN_W, 800: horizontal visible pixels
- SCREEN_H, 600: vertical visible pixels

Ports:
- clk  in  1  pixel clock, posedge
- rst  in  1  synchronous, active-high reset
- v_sync_in  in  1  VGA vertical sync; its rising edge is the frame tick
- left_click  in  1  mouse button level, already synchronous to clk
- reload_req  in  1  level; requests an early reload
- x_pos_in  in  12  mouse x
- y_pos_in  in  12  mouse y
- shot_done  in  1  renderer: bullet left screen (1-cycle pulse)
- hit  in  1  renderer: bullet hit target (1-cycle pulse)
- fire  out  1  1-cycle launch pulse to renderer
- frame_step  out  1  1-cycle pulse per frame tick while in FLIGHT
- target_x  out  12  latched target x
- target_y  out  12  latched target y
- busy  out  1  high in every state except IDLE
- ammo  out  4  remaining rounds
- score  out  8  hit counter, saturating

Behaviour:
- Reset:
  - State IDLE.
  - fire, frame_step and busy are 0.
  - target_x and target_y are 0.
  - ammo=AMMO_MAX, score=0.
  - Edge-detect registers and the frame counter are cleared.
  - A reset mid-operation aborts any flight; no fire is emitted afterwards.
- Edge detection:
  - click_rise = left_click & ~left_click_d.
  - frame_tick = v_sync_in & ~v_sync_d.
  - Both are registered, so each adds one cycle of latency.
- Clamping on latch:
  - target_x = min(x_pos_in, SCREEN_W-1).
  - target_y = min(y_pos_in, SCREEN_H-1); if y_pos_in is 0, target_y is forced to 1.
- All outputs are registered.
- FSM:
  - IDLE:
    - If ammo==0, go to RELOAD.
    - Else if reload_req and ammo<AMMO_MAX, go to RELOAD.
    - Else on click_rise: latch target, decrement ammo, go to ARM.
    - If click_rise and reload_req occur together, reload wins and the click is dropped.
  - ARM: wait for frame_tick, then go to FIRE.
  - FIRE:
    - fire=1 for exactly one cycle, then go to FLIGHT.
    - The frame counter clears on entry to FLIGHT.
  - FLIGHT:
    - frame_step mirrors frame_tick; the frame counter increments on each tick.
    - On hit, shot_done, or counter==FLIGHT_TIMEOUT, go to COOLDOWN.
    - hit increments score, saturating at 255.
    - hit and shot_done in the same cycle count as one hit.
    - A hit pulse outside FLIGHT is ignored.
  - COOLDOWN:
    - Count COOLDOWN_FRAMES frame_ticks.
    - Then go to RELOAD if ammo==0, else to IDLE.
  - RELOAD:
    - Count RELOAD_FRAMES frame_ticks.
    - Then set ammo=AMMO_MAX and go to IDLE.
- Clicks outside IDLE are discarded; there is no queue.
- Latency:
  - A click rising edge at cycle n is seen in IDLE at n+1.
  - fire is asserted one cycle after the registered frame_tick that follows entry to ARM.
  - target_x and target_y are stable from the ARM state until the next latch.
- Frame counter width: clog2 of the largest of the three frame parameters, plus 1.

Optional Feature:
- Macro SHOT_AUTO_FIRE_EN.
- When defined:
  - In IDLE, a held left_click (level) is treated as a click_rise.
  - Holding the button refires every flight+cooldown until ammo is exhausted, then reloads and continues.
- When undefined: only rising edges fire; holding the button yields exactly one shot.

Decomposition:
- Shared package (shot_pkg):
  - State encoding localparams: IDLE, ARM, FIRE, FLIGHT, COOLDOWN, RELOAD.
  - SCREEN_W/SCREEN_H defaults.
  - Coordinate width 12.
- Sub-module frame_timer:
  - Loadable down-counter decremented on frame_tick, with a done flag.
  - Shared by FLIGHT timeout, COOLDOWN and RELOAD.
- The edge detectors stay inline.

Test Plan:
- Basic shot:
  - Stimulus: rst, then click at x=300, y=200; frame_tick 3 cycles later.
  - Response: fire exactly 1 cycle; target=(300,200); ammo 8->7; busy high.
  - Then a hit pulse in FLIGHT: score=1; after 10 frames, IDLE.
- Clamp:
  - Stimulus: click at x=1023, y=0.
  - Response: target=(799,1).
- Ignored clicks:
  - Stimulus: 5 clicks during FLIGHT and COOLDOWN.
  - Response: no extra fire; ammo unchanged.
- Magazine exhaustion:
  - Stimulus: 8 completed shots.
  - Response: ammo=0; COOLDOWN then RELOAD; clicks are ignored for 60 frames; then ammo=8 and IDLE.
- Timeout and coincident pulses:
  - Stimulus: no done or hit for 120 frames.
  - Response: exactly 120 frame_step pulses, then COOLDOWN.
  - Stimulus: hit and shot_done in the same cycle.
  - Response: score increments by 1.
- Reset and auto-fire:
  - Stimulus: rst asserted in ARM.
  - Response: no fire; ammo=8, score=0.
  - With SHOT_AUTO_FIRE_EN and the button held: one shot per flight+cooldown period.
  - Without SHOT_AUTO_FIRE_EN and the button held: exactly one shot.
